// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: CPU bytes queue in a FIFO and a baud-timed shifter drains them back-to-back.
// Latency: a write into an idle, empty block drives txd low two edges later; a write while full is dropped and sets sticky tx_overflow.
module uart_tx_buffered #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_wr,
  input  logic [7:0]    tx_wdata,
  output logic          tx_tbr_valid,
  output logic          tx_busy,
  output logic [CW-1:0] tx_count,
  output logic          tx_overflow,
  input  logic          clr_ovrflw,
  output logic          txd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] DIV_M1   = BW'(DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          txd_nxt;
  logic          pop;
  logic          tc;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    head;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_wr),
    .wdata (tx_wdata),
    .pop   (pop),
    .rdata (head),
    .count (tx_count)
  );

  assign fifo_full    = (tx_count == FULL_CNT);
  assign fifo_empty   = (tx_count == '0);
  assign tx_tbr_valid = !fifo_full;
  assign tx_busy      = (state != IDLE) || !fifo_empty;
  assign tc           = (baud_cnt == '0);

  // txd is registered from the current state, so the line lags the FSM by one edge.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    txd_nxt   = 1'b1;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          baud_nxt  = DIV_M1;
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        txd_nxt = 1'b0;
        if (tc) begin
          baud_nxt  = DIV_M1;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt - BW'(1);
        end
      end
      DATA: begin
        txd_nxt = shift[0];
        if (tc) begin
          baud_nxt  = DIV_M1;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt - BW'(1);
        end
      end
      STOP: begin
        txd_nxt = 1'b1;
        if (tc) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            baud_nxt  = DIV_M1;
            bit_nxt   = '0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt - BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      txd      <= txd_nxt;
    end
  end

  // A write that finds the FIFO full wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_overflow <= 1'b0;
    end else if (tx_wr && fifo_full) begin
      tx_overflow <= 1'b1;
    end else if (clr_ovrflw) begin
      tx_overflow <= 1'b0;
    end
  end

endmodule

// Generic synchronous FIFO with occupancy count and show-ahead read data.
// Latency: one edge from push to visible head; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign push_ok = push && (count != FULL_CNT);
  assign pop_ok  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (!push_ok && pop_ok) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at DIV=10, FIFO_DEPTH=4: frame-level reference model, table vectors, line decoder.
module tb_uart_tx_buffered;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_wr;
  logic [7:0]    tx_wdata;
  logic          clr_ovrflw;
  logic          tx_tbr_valid;
  logic          tx_busy;
  logic [CW-1:0] tx_count;
  logic          tx_overflow;
  logic          txd;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH),
    .CW         (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_wr        (tx_wr),
    .tx_wdata     (tx_wdata),
    .tx_tbr_valid (tx_tbr_valid),
    .tx_busy      (tx_busy),
    .tx_count     (tx_count),
    .tx_overflow  (tx_overflow),
    .clr_ovrflw   (clr_ovrflw),
    .txd          (txd)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: a byte leaves the queue at the first edge where the queue is
  // non-empty and the previous frame (10*DIV edges from its pop) has run out.
  logic [7:0] mq[$];
  int         cyc       = -1;
  int         next_free = 0;
  int         cur_pop   = 0;
  bit         have      = 1'b0;
  logic [7:0] cur_byte  = 8'h00;
  bit         movf      = 1'b0;

  function automatic logic m_txd();
    int k, bi;
    if (!have) return 1'b1;
    k = cyc - cur_pop - 1;
    if (k < 0 || k >= FRAME) return 1'b1;
    bi = k / DIV;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return cur_byte[bi-1];
  endfunction

  function automatic logic m_busy();
    return (cyc < next_free) || (mq.size() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    movf      = 1'b0;
    have      = 1'b0;
    next_free = 0;
  endtask

  task automatic model_edge(input logic wr, input logic [7:0] d, input logic clr);
    int cnt;
    bit do_pop;
    cnt = mq.size();
    cyc++;
    do_pop = (cnt > 0) && (cyc >= next_free);
    if (wr && cnt == DEPTH) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (do_pop) begin
      cur_byte  = mq.pop_front();
      cur_pop   = cyc;
      next_free = cyc + FRAME;
      have      = 1'b1;
    end
    if (wr && cnt < DEPTH) mq.push_back(d);
  endtask

  logic hist[$];
  logic bhist[$];
  int   peak = 0;

  task automatic step(input logic wr, input logic [7:0] d, input logic clr);
    tx_wr      = wr;
    tx_wdata   = d;
    clr_ovrflw = clr;
    @(posedge clk);
    model_edge(wr, d, clr);
    #1;
    tx_wr      = 1'b0;
    clr_ovrflw = 1'b0;
    check("txd",   32'(txd),          32'(m_txd()));
    check("count", 32'(tx_count),     32'(mq.size()));
    check("tbr",   32'(tx_tbr_valid), 32'(mq.size() != DEPTH));
    check("busy",  32'(tx_busy),      32'(m_busy()));
    check("ovf",   32'(tx_overflow),  32'(movf));
    hist.push_back(txd);
    bhist.push_back(tx_busy);
    if (32'(tx_count) > 32'(peak)) peak = int'(tx_count);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_txd"},   32'(txd),          32'd1);
    check({tag, "_count"}, 32'(tx_count),     32'd0);
    check({tag, "_busy"},  32'(tx_busy),      32'd0);
    check({tag, "_tbr"},   32'(tx_tbr_valid), 32'd1);
    check({tag, "_ovf"},   32'(tx_overflow),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((m_busy() || tx_busy !== 1'b0) && n < limit) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    check("drain_in_time", 32'(n < limit), 32'd1);
  endtask

  logic [7:0] rx_bytes[$];
  int         rx_starts[$];
  int         rx_bad;

  // Independent line receiver: find each falling edge and sample mid-bit.
  task automatic decode();
    int i;
    logic [7:0] v;
    rx_bytes.delete();
    rx_starts.delete();
    rx_bad = 0;
    i = 1;
    while (i + FRAME <= hist.size()) begin
      if (hist[i-1] === 1'b1 && hist[i] === 1'b0) begin
        for (int b = 0; b < 8; b++) v[b] = hist[i + DIV*(b+1) + DIV/2];
        if (hist[i + 9*DIV + DIV/2] !== 1'b1) rx_bad++;
        rx_bytes.push_back(v);
        rx_starts.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    int         cnt;
    logic       tbr;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before 1000000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard, ones;
    logic [7:0] wrap_exp;

    tbl[0] = '{1'b1, 8'h10, 1'b0, 1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h12, 1'b0, 2, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h13, 1'b0, 3, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h14, 1'b0, 4, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h77, 1'b0, 4, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h78, 1'b1, 4, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 4, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 4, 1'b0, 1'b0};

    rst_n      = 1'b1;
    tx_wr      = 1'b0;
    tx_wdata   = 8'h00;
    clr_ovrflw = 1'b0;
    async_reset("por");
    repeat (5) step(1'b0, 8'h00, 1'b0);

    // Single byte 0xA5 into an idle block.
    hist.delete();
    bhist.delete();
    step(1'b1, 8'hA5, 1'b0);
    check("a5_count_after_write", 32'(tx_count), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("a5_count_after_pop", 32'(tx_count), 32'd0);
    check("a5_busy_after_pop",  32'(tx_busy),  32'd1);
    check("a5_txd_before_start", 32'(txd),     32'd1);
    for (int j = 2; j <= 110; j++) step(1'b0, 8'h00, 1'b0);
    decode();
    check("a5_frames",      32'(rx_bytes.size()), 32'd1);
    check("a5_byte",        32'(rx_bytes[0]),     32'hA5);
    check("a5_start_edge",  32'(rx_starts[0]),    32'd2);
    check("a5_stop_ok",     32'(rx_bad),          32'd0);
    check("a5_start_last",  32'(hist[11]),        32'd0);
    check("a5_bit0_first",  32'(hist[12]),        32'd1);
    check("a5_busy_in_stop", 32'(bhist[100]),     32'd1);
    check("a5_busy_idle",   32'(bhist[101]),      32'd0);

    // Reset in the middle of the start bit.
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("mid_start_txd_low", 32'(txd), 32'd0);
    async_reset("midrst");
    hist.delete();
    repeat (30) step(1'b0, 8'h00, 1'b0);
    ones = 0;
    foreach (hist[k]) if (hist[k] === 1'b1) ones++;
    check("post_reset_idle_high", 32'(ones), 32'd30);

    // Back-to-back writes on consecutive cycles.
    drain(2000);
    hist.delete();
    peak = 0;
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    drain(2000);
    decode();
    check("b2b_peak",   32'(peak),            32'd2);
    check("b2b_frames", 32'(rx_bytes.size()), 32'd3);
    check("b2b_byte0",  32'(rx_bytes[0]),     32'h00);
    check("b2b_byte1",  32'(rx_bytes[1]),     32'hFF);
    check("b2b_byte2",  32'(rx_bytes[2]),     32'h55);
    check("b2b_gap01",  32'(rx_starts[1] - rx_starts[0]), 32'(FRAME));
    check("b2b_gap12",  32'(rx_starts[2] - rx_starts[1]), 32'(FRAME));
    check("b2b_stop_ok", 32'(rx_bad),         32'd0);

    // Fill the FIFO behind an in-flight byte, overflow and the clear race.
    hist.delete();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].clr);
      check($sformatf("tbl%0d_count", i), 32'(tx_count),     32'(tbl[i].cnt));
      check($sformatf("tbl%0d_tbr", i),   32'(tx_tbr_valid), 32'(tbl[i].tbr));
      check($sformatf("tbl%0d_ovf", i),   32'(tx_overflow),  32'(tbl[i].ovf));
    end
    drain(2000);
    decode();
    check("fill_frames", 32'(rx_bytes.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("fill_byte%0d", i), 32'(rx_bytes[i]), 32'(8'h10 + i));

    // Wrap-around: 3*DEPTH incrementing bytes pushed whenever there is room.
    hist.delete();
    sent  = 0;
    guard = 0;
    while ((sent < 3*DEPTH || m_busy()) && guard < 5000) begin
      if (sent < 3*DEPTH && mq.size() < DEPTH) begin
        step(1'b1, 8'(sent), 1'b0);
        sent++;
      end else begin
        step(1'b0, 8'h00, 1'b0);
      end
      guard++;
    end
    check("wrap_in_time", 32'(guard < 5000), 32'd1);
    decode();
    check("wrap_frames", 32'(rx_bytes.size()), 32'(3*DEPTH));
    for (int i = 0; i < 3*DEPTH; i++) begin
      wrap_exp = 8'(i);
      check($sformatf("wrap_byte%0d", i), 32'(rx_bytes[i]), 32'(wrap_exp));
    end
    check("wrap_count_end", 32'(tx_count), 32'd0);

    // Randomized traffic with bursty write density, sporadic clears and one reset.
    for (int i = 0; i < 3000; i++) begin
      logic wr, clr;
      if (i == 1500) async_reset("rand_rst");
      wr  = ((i / 400) % 2 == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(wr, 8'($urandom), clr);
    end
    drain(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
